// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams bytes into the four byte-lane instruction memories and
//               holds the core in reset for the duration of the load.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int WORDS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] word_count,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [3:0] mem_we,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] checksum
);

  localparam logic [9:0] C_WORDS = 10'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [9:0] r_count;
  logic [9:0] r_last;
  logic [9:0] r_addr;
  logic [7:0] r_wdata;
  logic [3:0] r_we;
  logic [7:0] r_sum;
  logic       r_err;
  logic       w_legal;
  logic       w_accept;
  logic       w_load_go;
  logic [7:0] w_last_word;

  // A count of WORDS (256) wraps to 0 in eight bits, so minus one lands on 255.
  always_comb begin
    w_legal     = (word_count != 9'd0) && ({1'b0, word_count} <= C_WORDS);
    w_last_word = word_count[7:0] - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    w_accept   = 1'b0;
    w_load_go  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && w_legal) begin
          w_next    = S_LOAD;
          w_load_go = 1'b1;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        w_accept   = byte_valid;
        if (byte_valid && (r_count == r_last)) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        cpu_hold = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        cpu_hold = 1'b1;
        done     = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Write port is registered: a byte accepted at one edge is written at the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 10'd0;
      r_last  <= 10'd0;
      r_addr  <= 10'd0;
      r_wdata <= 8'd0;
      r_we    <= 4'd0;
      r_sum   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= start && (r_state == S_IDLE) && !w_legal;
      r_we  <= 4'd0;
      if (w_load_go) begin
        r_count <= 10'd0;
        r_sum   <= 8'd0;
        r_last  <= {w_last_word, 2'b11};
      end
      if (w_accept) begin
        r_we    <= 4'b0001 << r_count[1:0];
        r_addr  <= r_count;
        r_wdata <= byte_in;
        r_sum   <= r_sum + byte_in;
        r_count <= r_count + 10'd1;
      end
    end
  end

  always_comb begin
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mem_we    = r_we;
    err       = r_err;
    checksum  = r_sum;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory: it accepts a byte stream over a valid/ready handshake and writes it into the four byte-lane instruction memories, which are each addressed by `{word_index, lane}`. While a program load is in progress, it holds the processor in reset. Its outputs drive the write ports of the lane memories (byte 0 of a word goes to `rd[7:0]`, byte 3 to `rd[31:24]`) and the core's hold input. This allows a new program to be loaded without resynthesising the memory init files.

## Interface
- `WORDS`, default 256: instruction memory depth in 32-bit words. Word index width is 8 bits, byte address width is 10 bits.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: request a load. Sampled only in IDLE.
- `word_count` input, 9 bits: number of words to load. Legal range is 1..WORDS. Sampled together with `start`.
- `byte_in` input, 8 bits: stream data, little-endian within each word.
- `byte_valid` input, 1 bit: `byte_in` is valid this cycle.
- `byte_ready` output, 1 bit: the loader accepts a byte this cycle.
- `mem_addr` output, 10 bits: byte address `{word_index[7:0], lane[1:0]}`.
- `mem_wdata` output, 8 bits: write data for the selected lane.
- `mem_we` output, 4 bits: one-hot lane write enable. Bit n enables lane n.
- `cpu_hold` output, 1 bit: holds the processor in reset while loading.
- `busy` output, 1 bit: the loader is not in IDLE.
- `done` output, 1 bit: one-cycle pulse when a load completes.
- `err` output, 1 bit: one-cycle pulse when `start` is given with an illegal `word_count`.
- `checksum` output, 8 bits: sum mod 256 of all bytes accepted in the current or last load.

## Operation
- **States:** IDLE, LOAD, FLUSH, DONE.
- **IDLE:**
  - `byte_ready`=0, `busy`=0, `cpu_hold`=0.
  - On `start` with `word_count` in 1..WORDS: latch `last_byte = 4*word_count-1`, clear the byte counter and `checksum`, then go to LOAD.
  - On `start` with `word_count` = 0 or greater than WORDS: pulse `err` the next cycle and stay in IDLE. Counters and `checksum` are untouched.
- **LOAD:**
  - `byte_ready`=1, `cpu_hold`=1, `busy`=1.
  - A byte is accepted when `byte_valid` and `byte_ready` are both high.
  - On each accept:
    - register the write: `mem_addr` = byte counter, `mem_wdata` = `byte_in`, `mem_we` = one-hot of counter[1:0];
    - add the byte to `checksum`;
    - increment the counter.
  - When the accepted byte's counter equals `last_byte`, go to FLUSH.
  - A cycle without an accept produces `mem_we` = 0 on the following cycle.
- **FLUSH:**
  - `byte_ready`=0. The final registered write is presented on the memory outputs this cycle.
  - Unconditionally go to DONE.
- **DONE:**
  - `done`=1 and `cpu_hold`=1 for exactly one cycle, then go to IDLE.
  - `checksum` holds its value until the next legal `start`.
- **Ignored input:** `start` outside IDLE has no effect.
- **Addressing:** the byte counter is 10 bits and never wraps within a load. A full 256-word load ends at `mem_addr` = 0x3FF.
- **`mem_we` rule:** at most one bit is ever set. It is 0 in IDLE and DONE, and 0 in any cycle not following an accept.
- **Reset (any state, including mid-load):** on the next edge, go to IDLE; `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `checksum`=0, `done`=0, `err`=0, `byte_ready`=0, `cpu_hold`=0, `busy`=0. A partially loaded memory is not cleared.

## Timing
- A byte accepted at edge N is written at edge N+1: `mem_we`, `mem_addr` and `mem_wdata` are all registered and stable through cycle N+1.
- **Throughput:** one byte per cycle while `byte_valid` stays high. A back-to-back load of W words occupies 4W LOAD cycles.
- **Start to ready:** with `start` sampled at edge S, `byte_ready`=1 from cycle S+1.
- **End of load:** if the last byte is accepted at edge K:
  - cycle K+1 is FLUSH, with the last write on `mem_we`;
  - cycle K+2 has `done`=1;
  - cycle K+3 is IDLE, with `cpu_hold`=0.
- `err` is asserted in the cycle after the illegal `start` edge.

## Test plan
- **Back-to-back 2-word load.** `start`, `word_count`=2, bytes 13 00 00 00 93 01 50 00 with `byte_valid` held high.
  - Required: `mem_addr` 0..7 on consecutive cycles, `mem_we` 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
  - Required: `checksum` = 0xF7, `done` two cycles after the last accept, `cpu_hold` high from S+1 through the DONE cycle.
- **Gapped stream.** Same data as above, with `byte_valid` low on alternate cycles.
  - Required: same address/data sequence, `mem_we`=0 in each gap-following cycle, same `checksum`.
- **Illegal count.**
  - `start` with `word_count`=0: `err` pulses for one cycle, `busy` stays 0, no `mem_we`.
  - `start` with `word_count`=257: same result.
- **Reset mid-load.** Assert `reset` after 5 accepted bytes.
  - Required: next cycle shows IDLE with all outputs 0.
  - Required: a fresh 1-word load then writes `mem_addr` 0..3.
- **Full depth.** `word_count`=256 with incrementing bytes.
  - Required: the last write is at `mem_addr` 0x3FF with `mem_we`=1000, and `done` follows.
  - Required: `start` pulses during the load are ignored.
